// File: rtl/tr_midi_uart_fifo.sv
// tr_midi_uart_fifo: MIDI serial port for the MSX I/O bus.
//   8N1 UART with runtime-programmable bit divisor, TX/RX byte FIFOs of
//   2**FIFO_AW entries and a level interrupt.
// Ports:
//   clk21m     system clock (21.47727 MHz)
//   reset      synchronous, active-high
//   req/ack    bus request pulse / acknowledge one cycle later
//   wrt, adr   write strobe qualifier, register select
//   dbo/dbi    CPU write data / registered read data
//   pMidiTxD   serial out (idle high)
//   pMidiRxD   serial in (asynchronous)
//   pMidiIntr  interrupt, active-high level
// Build option: define TR_MIDI_LOOPBACK_EN to enable control[3] LOOP
//   (internal TxD feeds RX, pMidiTxD held high, pMidiRxD ignored).
module tr_midi_uart_fifo #(
  parameter int unsigned FIFO_AW     = 4,
  parameter int unsigned DIV_RESET   = 687,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk21m,
  input  logic       reset,
  input  logic       req,
  output logic       ack,
  input  logic       wrt,
  input  logic [1:0] adr,
  input  logic [7:0] dbo,
  output logic [7:0] dbi,
  output logic       pMidiTxD,
  input  logic       pMidiRxD,
  output logic       pMidiIntr
);
  localparam int unsigned CW = FIFO_AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} ser_state_e;

  logic [7:0]         tx_mem [2**FIFO_AW];
  logic [7:0]         rx_mem [2**FIFO_AW];
  logic [FIFO_AW-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
  logic [FIFO_AW-1:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
  logic [CW-1:0]      tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic               ack_q, intr_q, intr_d;
  logic [7:0]         dbi_q, dbi_d, status;
  logic [15:0]        div_q, div_d, div_eff;
  logic [2:0]         ctrl_q, ctrl_d;
  logic               oe_q, oe_d, fe_q, fe_d, tov_q, tov_d;
  logic [SYNC_STAGES-1:0] sync_q;

  ser_state_e  tx_st_q, tx_st_d, rx_st_q, rx_st_d;
  logic [15:0] tx_tmr_q, tx_tmr_d, tx_len_q, tx_len_d;
  logic [15:0] rx_tmr_q, rx_tmr_d, rx_len_q, rx_len_d;
  logic [2:0]  tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
  logic [7:0]  tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d;
  logic        txd_q, txd_d, rx_prev_q;
  logic        tx_end, tx_start, tx_pop, rx_end, rx_push, fe_set;

  logic tx_push, tx_push_ok, rx_pop_ok, rx_push_ok, ctrl_wr, erst, flush;
  logic tx_empty, tx_full, rx_empty, rx_full, txempty, loop, rx_in;

  assign tx_empty   = (tx_cnt_q == '0);
  assign tx_full    = tx_cnt_q[FIFO_AW];
  assign rx_empty   = (rx_cnt_q == '0);
  assign rx_full    = rx_cnt_q[FIFO_AW];
  assign txempty    = tx_empty & (tx_st_q == S_IDLE);

  assign tx_push    = req & wrt & (adr == 2'd0);
  assign tx_push_ok = tx_push & ~tx_full;
  assign rx_pop_ok  = req & ~wrt & (adr == 2'd0) & ~rx_empty;
  assign rx_push_ok = rx_push & ~rx_full;
  assign ctrl_wr    = req & wrt & (adr == 2'd1);
  assign erst       = ctrl_wr & dbo[4];
  assign flush      = ctrl_wr & dbo[6];
  assign div_eff    = (div_q < 16'd8) ? 16'd8 : div_q;
  assign status     = {2'b00, tov_q, fe_q, oe_q, txempty, ~rx_empty, ~tx_full};

`ifdef TR_MIDI_LOOPBACK_EN
  logic loop_q;
  always_ff @(posedge clk21m) begin
    if (reset || flush) loop_q <= 1'b0;
    else if (ctrl_wr)   loop_q <= dbo[3];
  end
  assign loop = loop_q;
  assign rx_in = loop_q ? txd_q : sync_q[SYNC_STAGES-1];
`else
  assign loop  = 1'b0;
  assign rx_in = sync_q[SYNC_STAGES-1];
`endif

  assign ack       = ack_q;
  assign dbi       = dbi_q;
  assign pMidiTxD  = txd_q | loop;
  assign pMidiIntr = intr_q;

  // Bus registers, FIFO pointers and error flags
  always_comb begin
    dbi_d    = dbi_q;
    div_d    = div_q;
    ctrl_d   = ctrl_q;
    tx_wp_d  = tx_wp_q + FIFO_AW'(tx_push_ok);
    tx_rp_d  = tx_rp_q + FIFO_AW'(tx_pop);
    tx_cnt_d = tx_cnt_q + CW'(tx_push_ok) - CW'(tx_pop);
    rx_wp_d  = rx_wp_q + FIFO_AW'(rx_push_ok);
    rx_rp_d  = rx_rp_q + FIFO_AW'(rx_pop_ok);
    rx_cnt_d = rx_cnt_q + CW'(rx_push_ok) - CW'(rx_pop_ok);
    oe_d     = (oe_q  & ~erst) | (rx_push & rx_full);
    fe_d     = (fe_q  & ~erst) | fe_set;
    tov_d    = (tov_q & ~erst) | (tx_push & tx_full);
    intr_d   = (ctrl_q[1] & ~rx_empty) | (ctrl_q[2] & txempty) | oe_q | fe_q;
    if (req && !wrt) begin
      case (adr)
        2'd0:    dbi_d = rx_empty ? 8'h00 : rx_mem[rx_rp_q];
        2'd1:    dbi_d = status;
        2'd2:    dbi_d = div_q[7:0];
        default: dbi_d = div_q[15:8];
      endcase
    end
    if (req && wrt) begin
      if (adr == 2'd1) ctrl_d = dbo[2:0];
      if (adr == 2'd2) div_d[7:0]  = dbo;
      if (adr == 2'd3) div_d[15:8] = dbo;
    end
    if (flush) begin
      tx_wp_d = '0; tx_rp_d = '0; tx_cnt_d = '0;
      rx_wp_d = '0; rx_rp_d = '0; rx_cnt_d = '0;
    end
  end

  // TX: bit length is latched at each bit boundary so divisor writes
  // never stretch or truncate the bit in flight.
  always_comb begin
    tx_st_d  = tx_st_q;
    tx_tmr_d = tx_tmr_q + 16'd1;
    tx_len_d = tx_len_q;
    tx_bit_d = tx_bit_q;
    tx_sh_d  = tx_sh_q;
    txd_d    = txd_q;
    tx_pop   = 1'b0;
    tx_start = 1'b0;
    tx_end   = (tx_tmr_q == tx_len_q - 16'd1);
    case (tx_st_q)
      S_IDLE: begin
        tx_tmr_d = '0;
        tx_start = ctrl_q[0] & ~tx_empty;
      end
      S_START: if (tx_end) begin
        tx_st_d  = S_DATA;
        tx_bit_d = '0;
        txd_d    = tx_sh_q[0];
      end
      S_DATA: if (tx_end) begin
        if (tx_bit_q == 3'd7) begin
          tx_st_d = S_STOP;
          txd_d   = 1'b1;
        end else begin
          tx_bit_d = tx_bit_q + 3'd1;
          tx_sh_d  = tx_sh_q >> 1;
          txd_d    = tx_sh_q[1];
        end
      end
      S_STOP: if (tx_end) begin
        tx_start = ctrl_q[0] & ~tx_empty;
        tx_st_d  = S_IDLE;
      end
      default: tx_st_d = S_IDLE;
    endcase
    if (tx_end && tx_st_q != S_IDLE) begin
      tx_tmr_d = '0;
      tx_len_d = div_eff;
    end
    if (tx_start) begin
      tx_pop   = 1'b1;
      tx_sh_d  = tx_mem[tx_rp_q];
      tx_st_d  = S_START;
      txd_d    = 1'b0;
      tx_tmr_d = '0;
      tx_len_d = div_eff;
    end
    if (flush) begin
      tx_st_d  = S_IDLE;
      txd_d    = 1'b1;
      tx_tmr_d = '0;
      tx_pop   = 1'b0;
    end
  end

  // RX: start bit is re-checked at half a bit; data/stop sampled mid-bit
  always_comb begin
    rx_st_d  = rx_st_q;
    rx_tmr_d = rx_tmr_q + 16'd1;
    rx_len_d = rx_len_q;
    rx_bit_d = rx_bit_q;
    rx_sh_d  = rx_sh_q;
    rx_push  = 1'b0;
    fe_set   = 1'b0;
    rx_end   = (rx_tmr_q == rx_len_q - 16'd1);
    case (rx_st_q)
      S_IDLE: begin
        rx_tmr_d = '0;
        if (rx_prev_q && !rx_in) begin
          rx_st_d  = S_START;
          rx_len_d = div_eff;
        end
      end
      S_START: if (rx_tmr_q == {1'b0, rx_len_q[15:1]} - 16'd1) begin
        rx_tmr_d = '0;
        rx_len_d = div_eff;
        rx_bit_d = '0;
        rx_st_d  = rx_in ? S_IDLE : S_DATA;
      end
      S_DATA: if (rx_end) begin
        rx_tmr_d = '0;
        rx_len_d = div_eff;
        rx_sh_d  = {rx_in, rx_sh_q[7:1]};
        if (rx_bit_q == 3'd7) rx_st_d = S_STOP;
        else                  rx_bit_d = rx_bit_q + 3'd1;
      end
      S_STOP: if (rx_end) begin
        rx_push = 1'b1;
        fe_set  = ~rx_in;
        rx_st_d = S_IDLE;
      end
      default: rx_st_d = S_IDLE;
    endcase
    if (flush) begin
      rx_st_d = S_IDLE;
      rx_push = 1'b0;
      fe_set  = 1'b0;
    end
  end

  always_ff @(posedge clk21m) begin
    if (tx_push_ok) tx_mem[tx_wp_q] <= dbo;
    if (rx_push_ok) rx_mem[rx_wp_q] <= rx_sh_q;
  end

  always_ff @(posedge clk21m) begin
    if (reset) begin
      ack_q   <= 1'b0;  dbi_q  <= '0;  intr_q <= 1'b0;
      div_q   <= 16'(DIV_RESET);       ctrl_q <= '0;
      oe_q    <= 1'b0;  fe_q   <= 1'b0;  tov_q <= 1'b0;
      tx_wp_q <= '0;  tx_rp_q <= '0;  tx_cnt_q <= '0;
      rx_wp_q <= '0;  rx_rp_q <= '0;  rx_cnt_q <= '0;
      sync_q  <= '1;  rx_prev_q <= 1'b1;
      tx_st_q <= S_IDLE;  tx_tmr_q <= '0;  tx_len_q <= 16'(DIV_RESET);
      tx_bit_q <= '0;  tx_sh_q <= '0;  txd_q <= 1'b1;
      rx_st_q <= S_IDLE;  rx_tmr_q <= '0;  rx_len_q <= 16'(DIV_RESET);
      rx_bit_q <= '0;  rx_sh_q <= '0;
    end else begin
      ack_q   <= req;  dbi_q <= dbi_d;  intr_q <= intr_d;
      div_q   <= div_d;  ctrl_q <= ctrl_d;
      oe_q    <= oe_d;  fe_q <= fe_d;  tov_q <= tov_d;
      tx_wp_q <= tx_wp_d;  tx_rp_q <= tx_rp_d;  tx_cnt_q <= tx_cnt_d;
      rx_wp_q <= rx_wp_d;  rx_rp_q <= rx_rp_d;  rx_cnt_q <= rx_cnt_d;
      sync_q  <= {sync_q[SYNC_STAGES-2:0], pMidiRxD};
      rx_prev_q <= rx_in;
      tx_st_q <= tx_st_d;  tx_tmr_q <= tx_tmr_d;  tx_len_q <= tx_len_d;
      tx_bit_q <= tx_bit_d;  tx_sh_q <= tx_sh_d;  txd_q <= txd_d;
      rx_st_q <= rx_st_d;  rx_tmr_q <= rx_tmr_d;  rx_len_q <= rx_len_d;
      rx_bit_q <= rx_bit_d;  rx_sh_q <= rx_sh_d;
    end
  end

endmodule

// File: tb/tb_tr_midi_uart_fifo.sv
`timescale 1ns/1ps
module tb_tr_midi_uart_fifo;
  localparam int unsigned FIFO_AW = 4;
  localparam int DEPTH = 1 << FIFO_AW;

  logic       clk21m = 1'b0;
  logic       reset, req, wrt, pMidiRxD;
  logic [1:0] adr;
  logic [7:0] dbo, dbi;
  logic       ack, pMidiTxD, pMidiIntr;

  int         n_checks = 0;
  int         n_errors = 0;
  int         bitlen   = 687;
  int         n_frames = 0;
  logic       oe_exp   = 1'b0;
  logic [7:0] txq [$];
  logic [7:0] rxq [$];
  time        frame_t [$];

  always #5 clk21m = ~clk21m;

  tr_midi_uart_fifo #(.FIFO_AW(FIFO_AW), .DIV_RESET(687), .SYNC_STAGES(2)) u_dut (
    .clk21m(clk21m), .reset(reset), .req(req), .ack(ack), .wrt(wrt),
    .adr(adr), .dbo(dbo), .dbi(dbi), .pMidiTxD(pMidiTxD),
    .pMidiRxD(pMidiRxD), .pMidiIntr(pMidiIntr)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [7:0] v);
    @(posedge clk21m); #1;
    req = 1'b1; wrt = 1'b1; adr = a; dbo = v;
    @(posedge clk21m); #1;
    req = 1'b0; wrt = 1'b0;
    check_val("ack_wr", 32'(ack), 32'd1);
  endtask

  task automatic bus_rd(input logic [1:0] a, output logic [7:0] v);
    @(posedge clk21m); #1;
    req = 1'b1; wrt = 1'b0; adr = a;
    @(posedge clk21m); #1;
    req = 1'b0;
    check_val("ack_rd", 32'(ack), 32'd1);
    v = dbi;
  endtask

  task automatic rd_rx();
    logic [7:0] v;
    logic [7:0] e;
    bus_rd(2'd0, v);
    e = (rxq.size() != 0) ? rxq.pop_front() : 8'h00;
    check_val("rx_data", 32'(v), 32'(e));
  endtask

  task automatic rx_bit(input logic v);
    pMidiRxD = v;
    repeat (bitlen) @(posedge clk21m);
    #1;
  endtask

  // Scoreboard side: the queue models RX FIFO contents
  task automatic rx_send(input logic [7:0] b, input logic stop);
    @(posedge clk21m); #1;
    rx_bit(1'b0);
    for (int i = 0; i < 8; i++) rx_bit(b[i]);
    rx_bit(stop);
    rx_bit(1'b1);
    if (rxq.size() < DEPTH) rxq.push_back(b);
    else oe_exp = 1'b1;
  endtask

  task automatic wait_tx_drain(input int budget);
    int n = 0;
    while (txq.size() != 0 && n < budget) begin
      @(posedge clk21m);
      n++;
    end
    #1;
    check_val("tx_drain", 32'(txq.size()), 32'd0);
  endtask

  // TX monitor: decodes frames mid-bit and pops the expected queue
  initial begin : tx_mon
    logic [7:0] b;
    int         l;
    time        t0;
    forever begin
      @(negedge pMidiTxD);
      t0 = $time;
      l  = bitlen;
      repeat (l / 2) @(posedge clk21m);
      #1;
      if (pMidiTxD == 1'b0) begin
        for (int i = 0; i < 8; i++) begin
          repeat (l) @(posedge clk21m);
          #1;
          b[i] = pMidiTxD;
        end
        repeat (l) @(posedge clk21m);
        #1;
        check_val("tx_stop", 32'(pMidiTxD), 32'd1);
        frame_t.push_back(t0);
        n_frames++;
        check_val("tx_pending", 32'(txq.size() != 0), 32'd1);
        if (txq.size() != 0) check_val("tx_data", 32'(b), 32'(txq.pop_front()));
      end
    end
  end

  initial begin : watchdog
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [7:0] d;
    int         base;
    int         lows;
    reset = 1'b1; req = 1'b0; wrt = 1'b0; adr = '0; dbo = '0; pMidiRxD = 1'b1;
    repeat (3) @(posedge clk21m);
    #1;
    check_val("rst_ack",  32'(ack), 32'd0);
    check_val("rst_dbi",  32'(dbi), 32'd0);
    check_val("rst_txd",  32'(pMidiTxD), 32'd1);
    check_val("rst_intr", 32'(pMidiIntr), 32'd0);
    reset = 1'b0;
    bus_rd(2'd1, d); check_val("rst_status", 32'(d), 32'h05);
    bus_rd(2'd2, d); check_val("rst_div_lo", 32'(d), 32'hAF);
    bus_rd(2'd3, d); check_val("rst_div_hi", 32'(d), 32'h02);

    // Three back-to-back frames at the reset divisor
    frame_t.delete();
    bus_wr(2'd1, 8'h01);
    bus_wr(2'd0, 8'h90); txq.push_back(8'h90);
    bus_wr(2'd0, 8'h3C); txq.push_back(8'h3C);
    bus_wr(2'd0, 8'h64); txq.push_back(8'h64);
    wait_tx_drain(40000);
    bus_rd(2'd1, d); check_val("t1_txempty_busy", 32'(d[2]), 32'd0);
    repeat (bitlen) @(posedge clk21m);
    bus_rd(2'd1, d); check_val("t1_txempty_done", 32'(d[2]), 32'd1);
    check_val("t1_frames", 32'(frame_t.size()), 32'd3);
    if (frame_t.size() == 3) begin
      check_val("t1_gap1", 32'(frame_t[1] - frame_t[0]), 32'(10 * 687 * 10));
      check_val("t1_gap2", 32'(frame_t[2] - frame_t[1]), 32'(10 * 687 * 10));
    end

    // RX byte at the reset divisor, RXIE interrupt
    bus_wr(2'd1, 8'h02);
    rx_send(8'hA5, 1'b1);
    bus_rd(2'd1, d);
    check_val("t2_rxne", 32'(d[1]), 32'd1);
    check_val("t2_fe",   32'(d[4]), 32'd0);
    check_val("t2_intr", 32'(pMidiIntr), 32'd1);
    rd_rx();
    bus_rd(2'd1, d); check_val("t2_rxne_clr", 32'(d[1]), 32'd0);
    repeat (2) @(posedge clk21m);
    #1;
    check_val("t2_intr_clr", 32'(pMidiIntr), 32'd0);

    bus_wr(2'd2, 8'd16); bus_wr(2'd3, 8'd0); bitlen = 16;

    // TX overflow: 17 pushes with TXEN=0, only 16 may be sent
    bus_wr(2'd1, 8'h00);
    for (int i = 0; i < DEPTH + 1; i++) begin
      d = 8'h30 + 8'(i);
      bus_wr(2'd0, d);
      if (i < DEPTH) txq.push_back(d);
    end
    bus_rd(2'd1, d);
    check_val("t3_notfull", 32'(d[0]), 32'd0);
    check_val("t3_tov",     32'(d[5]), 32'd1);
    base = n_frames;
    bus_wr(2'd1, 8'h01);
    wait_tx_drain(DEPTH * 10 * 16 + 2000);
    repeat (30 * bitlen) @(posedge clk21m);
    check_val("t3_frames", 32'(n_frames - base), 32'(DEPTH));
    bus_wr(2'd1, 8'h10);
    bus_rd(2'd1, d); check_val("t3_tov_clr", 32'(d[5]), 32'd0);

    // Divisor below 8 behaves as 8
    bus_wr(2'd2, 8'd3); bitlen = 8;
    bus_rd(2'd2, d); check_val("div_raw", 32'(d), 32'd3);
    bus_wr(2'd1, 8'h01);
    bus_wr(2'd0, 8'hC3); txq.push_back(8'hC3);
    wait_tx_drain(400);
    repeat (20) @(posedge clk21m);
    bus_wr(2'd1, 8'h00);
    bus_wr(2'd2, 8'd16); bitlen = 16;

    // RX overflow
    oe_exp = 1'b0;
    for (int i = 1; i <= DEPTH + 1; i++) rx_send(8'(i), 1'b1);
    bus_rd(2'd1, d);
    check_val("t4_oe", 32'(d[3]), 32'(oe_exp));
    check_val("t4_intr", 32'(pMidiIntr), 32'd1);
    for (int i = 0; i < DEPTH + 1; i++) rd_rx();
    bus_wr(2'd1, 8'h10);
    bus_rd(2'd1, d); check_val("t4_oe_clr", 32'(d[3]), 32'd0);
    repeat (2) @(posedge clk21m);
    #1;
    check_val("t4_intr_clr", 32'(pMidiIntr), 32'd0);

    // FLUSH empties both FIFOs
    bus_wr(2'd0, 8'h11); bus_wr(2'd0, 8'h22);
    rx_send(8'h77, 1'b1);
    bus_rd(2'd1, d); check_val("fl_pre", 32'(d), 32'h03);
    bus_wr(2'd1, 8'h40);
    rxq.delete();
    bus_rd(2'd1, d); check_val("fl_post", 32'(d), 32'h05);
    base = n_frames;
    bus_wr(2'd1, 8'h01);
    repeat (200) @(posedge clk21m);
    check_val("fl_no_tx", 32'(n_frames - base), 32'd0);
    bus_wr(2'd1, 8'h00);

`ifdef TR_MIDI_LOOPBACK_EN
    bus_wr(2'd1, 8'h0B);
    pMidiRxD = 1'b0;
    bus_wr(2'd0, 8'h5A); rxq.push_back(8'h5A);
    lows = 0;
    for (int i = 0; i < 12 * bitlen; i++) begin
      @(posedge clk21m);
      #1;
      if (pMidiTxD == 1'b0) lows++;
    end
    check_val("lb_txd_high", 32'(lows), 32'd0);
    rd_rx();
    pMidiRxD = 1'b1;
    repeat (4) @(posedge clk21m);
    bus_wr(2'd1, 8'h00);
`else
    lows = 0;
`endif

    // Framing error then a short glitch
    rx_send(8'h4D, 1'b0);
    bus_rd(2'd1, d);
    check_val("t5_fe",   32'(d[4]), 32'd1);
    check_val("t5_rxne", 32'(d[1]), 32'd1);
    check_val("t5_intr", 32'(pMidiIntr), 32'd1);
    rd_rx();
    @(posedge clk21m); #1;
    pMidiRxD = 1'b0;
    repeat (3) @(posedge clk21m);
    #1;
    pMidiRxD = 1'b1;
    repeat (20 * bitlen) @(posedge clk21m);
    bus_rd(2'd1, d); check_val("t5_glitch", 32'(d), 32'h15);

    // Reset in the middle of a TX frame
    bus_wr(2'd1, 8'h01);
    bus_wr(2'd0, 8'hE7);
    repeat (4) @(posedge clk21m);
    #1;
    reset = 1'b1;
    @(posedge clk21m);
    #1;
    check_val("mr_txd",  32'(pMidiTxD), 32'd1);
    check_val("mr_ack",  32'(ack), 32'd0);
    check_val("mr_dbi",  32'(dbi), 32'd0);
    reset = 1'b0;
    base = n_frames;
    bus_rd(2'd1, d); check_val("mr_status", 32'(d), 32'h05);
    repeat (12 * bitlen) @(posedge clk21m);
    #1;
    check_val("mr_intr", 32'(pMidiIntr), 32'd0);
    check_val("mr_no_tx", 32'(n_frames - base), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
